// File: rtl/sat_pkg.sv
// Shared types and saturation bounds for the saturating accumulator.
package sat_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Largest representable two's complement value for a w-bit word.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest representable two's complement value for a w-bit word.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed adder that clamps to the representable range.
module sat_add_signed
  import sat_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    clamped
);

  localparam logic signed [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_VAL = WIDTH'(sat_min(WIDTH));

  logic signed [WIDTH:0] wide;
  logic                  overflow;

  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // Operands of equal sign whose truncated result flips sign have overflowed;
  // the direction of the clamp follows the operand sign.
  always_comb begin
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
    clamped  = overflow;
    if (overflow) begin
      sum = a[WIDTH-1] ? MIN_VAL : MAX_VAL;
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sat_acc_sequencer.sv
// Burst accumulator: sums samples with per-step saturation and hands the
// total, a sticky clamp flag and a saturating sample count to a consumer.
module sat_acc_sequencer
  import sat_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_sat,
  output logic [COUNT_W-1:0] out_count
);

  state_t                   state_reg;
  state_t                   state_next;
  logic signed [WIDTH-1:0]  acc_reg;
  logic                     sat_reg;
  logic [COUNT_W-1:0]       count_reg;
  logic signed [WIDTH-1:0]  add_sum;
  logic                     add_clamped;
  logic                     take;
  logic                     release_burst;

  sat_add_signed #(.WIDTH(WIDTH)) u_add (
    .a       (acc_reg),
    .b       (in_data),
    .sum     (add_sum),
    .clamped (add_clamped)
  );

  assign take          = in_valid & in_ready;
  assign release_burst = (state_reg == HOLD) & out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state; handshake outputs decode from state only.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // Accumulator, sticky clamp flag and saturating count; cleared when the
  // consumer takes the result so the next burst starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
      count_reg <= '0;
    end else if (release_burst) begin
      acc_reg   <= '0;
      sat_reg   <= 1'b0;
      count_reg <= '0;
    end else if (take) begin
      acc_reg   <= add_sum;
      sat_reg   <= sat_reg | add_clamped;
      if (count_reg != '1) count_reg <= count_reg + 1'b1;
    end
  end

  assign out_sum   = acc_reg;
  assign out_sat   = sat_reg;
  assign out_count = count_reg;

endmodule

// File: tb/tb_sat_acc_sequencer.sv
// Randomised and directed bench for sat_acc_sequencer with a result scoreboard.
module tb_sat_acc_sequencer;

  localparam int WIDTH   = 4;
  localparam int COUNT_W = 4;
  localparam int MAXV    = 7;
  localparam int MINV    = -8;
  localparam int CMAX    = 15;

  typedef struct packed {
    logic [WIDTH-1:0]   sum;
    logic               sat;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   out_sum;
  logic               out_sat;
  logic [COUNT_W-1:0] out_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   rand_ready = 1'b0;

  // Reference model state: plain integers.
  int   m_acc = 0;
  bit   m_sat = 1'b0;
  int   m_cnt = 0;

  sat_acc_sequencer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_sat = 1'b0;
    m_cnt = 0;
  endtask

  // Offer one sample and wait (bounded) for it to be accepted; the model
  // advances only on acceptance, and a final sample queues the expected result.
  task automatic send(input logic [WIDTH-1:0] d, input bit last);
    bit ok;
    int raw;
    int clampv;
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      raw    = m_acc + int'($signed(d));
      clampv = (raw > MAXV) ? MAXV : ((raw < MINV) ? MINV : raw);
      if (clampv != raw) m_sat = 1'b1;
      m_acc = clampv;
      if (m_cnt < CMAX) m_cnt++;
      if (last) begin
        e.sum = WIDTH'(m_acc);
        e.sat = m_sat;
        e.cnt = COUNT_W'(m_cnt);
        exp_q.push_back(e);
        $display("burst queued: sum=%0d sat=%0d count=%0d", m_acc, m_sat, m_cnt);
        model_reset();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitor: every cycle a result is presented it must match the oldest
  // queued expectation; it is retired on the handshake.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_result: got sum=%0d count=%0d expected no result", out_sum, out_count);
      end else begin
        if (out_sum !== exp_q[0].sum || out_sat !== exp_q[0].sat || out_count !== exp_q[0].cnt) begin
          n_errors++;
          $display("FAIL result: got sum=%0d sat=%0d count=%0d expected sum=%0d sat=%0d count=%0d",
                   $signed(out_sum), out_sat, out_count,
                   $signed(exp_q[0].sum), exp_q[0].sat, exp_q[0].cnt);
        end
        if (out_ready) begin
          $display("result taken: sum=%0d sat=%0d count=%0d", $signed(out_sum), out_sat, out_count);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Random consumer backpressure during the randomised phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    // Reset values.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_count", out_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Burst 1,2,-1: result one cycle after last, in_ready low exactly one cycle.
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'hF, 1'b1);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_in_ready", in_ready, 0);
    chk("b1_sum", out_sum, 2);
    chk("b1_count", out_count, 3);
    cyc();
    @(negedge clk);
    chk("after_hs_in_ready", in_ready, 1);
    chk("after_hs_out_valid", out_valid, 0);
    cyc();

    // 4,7,-3: clamps at 7 then ends at 4.
    send(4'd4, 1'b0);
    send(4'd7, 1'b0);
    @(negedge clk);
    chk("b2_mid_sum", out_sum, 7);
    chk("b2_mid_sat", out_sat, 1);
    cyc();
    send(4'hD, 1'b1);
    idle(2);

    // Negative saturation, then a clean burst showing the flag cleared.
    send(4'hC, 1'b0);
    send(4'h9, 1'b0);
    send(4'hF, 1'b1);
    idle(2);
    send(4'hC, 1'b0);
    send(4'd4, 1'b1);
    idle(2);

    // Backpressure for 5 cycles with a sample offered during HOLD.
    out_ready = 1'b0;
    send(4'd2, 1'b0);
    send(4'd1, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'd3;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      cyc();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Single sample -8 after input gaps.
    idle(3);
    send(4'h8, 1'b1);
    idle(2);

    // Count saturates at 15 over 20 samples.
    for (int i = 0; i < 20; i++) send(4'd0, i == 19);
    idle(2);

    // Reset mid-burst discards the partial sum immediately.
    send(4'd3, 1'b0);
    send(4'd3, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_sum", out_sum, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_sat", out_sat, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    send(4'd2, 1'b1);
    idle(2);

    // Randomised bursts with random gaps and consumer backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(WIDTH'($urandom_range(0, 15)), s == len - 1);
      end
    end

    // Drain outstanding results.
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
    idle(2);
    chk("drain_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sat_acc_sequencer.md
Name: sat_acc_sequencer

Overview:
- Streaming controller that sequences a signed saturating adder to sum bursts of signed samples.
- Accepts samples over a valid/ready input and accumulates them with saturation at every step.
- Presents the burst total, a sticky saturation flag and a sample count over a valid/ready output.
- Sits between a sample producer and any consumer needing clamped signed sums, e.g. board display or audio-style mixing labs.

Parameters:
- WIDTH, 4, sample and sum width in bits, two's complement signed; minimum 2.
- COUNT_W, 4, width of the per-burst sample counter.

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample present
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  WIDTH  signed sample
- in_last  input  1  marks the final sample of the burst; qualified by in_valid
- out_valid  output  1  burst result held
- out_ready  input  1  consumer takes the result
- out_sum  output  WIDTH  signed saturated total
- out_sat  output  1  clamping occurred at least once in the burst
- out_count  output  COUNT_W  samples accepted in the burst; saturates at 2^COUNT_W-1

Behaviour:
- Reset asserted (asynchronous): state=ACC, acc=0, sat flag=0, count=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_sum=0, out_sat=0, out_count=0.
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Arithmetic:
  - MAX=2^(WIDTH-1)-1, MIN=-2^(WIDTH-1).
  - next = clamp(acc + in_data), computed at WIDTH+1 bits and clamped to [MAX, MIN].
  - Clamping is applied per step, not to the final total: 7 then +1 then -3 gives 4, not 5.
  - Overflow is detected when both operands have the same sign and the result sign differs.
- ACC transfer (in_valid & in_ready):
  - acc<=next.
  - sat<=sat | clamped.
  - count<=count+1, saturating at the maximum.
- ACC with in_last on a transfer:
  - Go to HOLD next cycle.
  - out_sum/out_sat/out_count reflect the final sample.
  - Latency: result visible 1 cycle after the last sample is accepted.
- HOLD:
  - Outputs stable while out_ready=0.
  - On out_ready: return to ACC next cycle; acc, sat and count cleared to 0 in the same edge.
  - No sample is accepted in the handshake cycle, so throughput is one burst per (N+1) cycles minimum.
- Single-sample burst (in_last on the first sample): out_sum=in_data, out_sat=0, out_count=1.
- in_valid=0 in ACC: holds all state; gaps inside a burst are allowed.
- in_last without in_valid: ignored.
- out_sum, out_sat and out_count are driven directly from registers in both states.
  - In ACC they show the running partial values, but these are meaningful only when out_valid=1.
- Reset mid-burst or in HOLD: the partial burst is discarded and all outputs return to reset values immediately.
- No combinational path from in_valid or out_ready to in_ready/out_valid; both are decoded from state only.

Decomposition:
- Shared package sat_pkg:
  - State enum {ACC, HOLD}.
  - Functions sat_max(WIDTH) and sat_min(WIDTH).
- Sub-module sat_add_signed (WIDTH parameter):
  - Combinational a+b with clamping.
  - Outputs sum and a 1-bit clamped flag.
  - The sequencer instantiates one instance.
- The FSM, counter and registers stay in sat_acc_sequencer.

Test Plan (WIDTH=4, COUNT_W=4):
- Burst 1,2,-1 (last), out_ready=1 → out_valid one cycle after last, out_sum=2, out_sat=0, out_count=3; in_ready=0 exactly one cycle.
- Burst 4,7,-3 (last) → 7 after step 2 (clamped), final out_sum=4, out_sat=1, out_count=3.
- Burst -4,-7,-1 (last) → out_sum=-8, out_sat=1; then burst -4,4 → out_sum=0, out_sat=0 (flag cleared between bursts).
- Backpressure: out_ready=0 for 5 cycles after result → out_valid, out_sum, out_count stable and in_ready=0 throughout; in_valid with data 3 during HOLD is not consumed.
- Single sample -8 with in_last and in_valid gaps before it → out_sum=-8, out_count=1, out_sat=0.
- Count saturation and reset:
  - 20 samples of 0 → out_count=15.
  - reset_n pulsed low mid-burst after 3,3 → outputs 0 and in_ready=1 immediately.
  - Next burst 2 (last) → out_sum=2.
